if_id_buffer: RTL and testbench

- Two-entry IF->ID pipeline buffer between the fetch stage and the decode stage of the five-stage MIPS CPU.
- Captures {predict flag, pc, inst} from fetch and presents them in order to decode under a valid/allow-in handshake.
- Flushes wrong-path instructions on mispredict or exception, optionally keeping the branch delay slot.
- Keeps saturating flush and squash statistics for the display/debug path.

---
 rtl/if_id_buffer.sv | 120 ++++++++++++
 tb/tb_if_id_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// IF->ID two-entry skid buffer with flush, delay-slot keep
// and saturating flush/squash statistics.
module if_id_buffer #(
   parameter int CNT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IF_over,
   input  logic [63:0]      IF_ID_bus,
   input  logic             IF_pred_taken,
   output logic             IF_allow_in,
   input  logic             ID_allow_in,
   output logic             ID_valid,
   output logic [64:0]      ID_bus,
   input  logic             flush,
   input  logic             flush_keep_head,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] squash_cnt
);

   if (DEPTH != 2) begin : g_bad_depth
      $error("if_id_buffer: DEPTH must be 2");
   end

   logic [64:0]      mem_q [2];
   logic [64:0]      mem_d [2];
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

   logic             offer;
   logic             push;
   logic             pop;
   logic [1:0]       drop;
   logic [1:0]       sq_inc;
   logic [CNT_W:0]   fc_sum;
   logic [CNT_W:0]   sc_sum;

   // Outputs depend on registered state only (no IF_over/ID_allow_in path)
   always_comb begin
      IF_allow_in = (count_q != 2'd2);
      ID_valid    = (count_q != 2'd0);
      ID_bus      = ID_valid ? mem_q[head_q] : 65'h0;
      occupancy   = count_q;
      flush_cnt   = flush_cnt_q;
      squash_cnt  = squash_cnt_q;
   end

   // Next-state: push/pop bookkeeping, flush squashing, counters
   always_comb begin
      mem_d    = mem_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      drop     = 2'd0;
      sq_inc   = 2'd0;
      fc_sum   = {1'b0, flush_cnt_q};
      sc_sum   = {1'b0, squash_cnt_q};

      offer = IF_over & IF_allow_in;
      push  = offer & ~flush;
      pop   = ID_valid & ID_allow_in;

      if (push) begin
         mem_d[tail_q] = {IF_pred_taken, IF_ID_bus};
         tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      if (flush) begin
         if (flush_keep_head && !pop && count_q != 2'd0) begin
            // delay slot stays at the head, younger entries go
            head_d  = head_q;
            tail_d  = head_q + 1'b1;
            count_d = 2'd1;
            drop    = count_q - 2'd1;
         end else begin
            // a popped head was consumed, not squashed
            tail_d  = head_d;
            count_d = 2'd0;
            drop    = count_q - {1'b0, pop};
         end
         sq_inc = drop + {1'b0, offer};
         fc_sum = {1'b0, flush_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
         sc_sum = {1'b0, squash_cnt_q}
                + {{(CNT_W-1){1'b0}}, sq_inc};
      end

      flush_cnt_d  = fc_sum[CNT_W] ? '1 : fc_sum[CNT_W-1:0];
      squash_cnt_d = sc_sum[CNT_W] ? '1 : sc_sum[CNT_W-1:0];
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0]     <= 65'h0;
         mem_q[1]     <= 65'h0;
         head_q       <= 1'b0;
         tail_q       <= 1'b0;
         count_q      <= 2'd0;
         flush_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         mem_q        <= mem_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         flush_cnt_q  <= flush_cnt_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed table,
// hand-written corner sequences and a randomized queue model.
module tb_if_id_buffer;

   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          IF_over;
   logic [63:0]   IF_ID_bus;
   logic          IF_pred_taken;
   logic          IF_allow_in;
   logic          ID_allow_in;
   logic          ID_valid;
   logic [64:0]   ID_bus;
   logic          flush;
   logic          flush_keep_head;
   logic [1:0]    occupancy;
   logic [CW-1:0] flush_cnt;
   logic [CW-1:0] squash_cnt;

   int n_vec = 0;
   int n_err = 0;

   if_id_buffer #(.CNT_W(CW), .DEPTH(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .IF_over         (IF_over),
      .IF_ID_bus       (IF_ID_bus),
      .IF_pred_taken   (IF_pred_taken),
      .IF_allow_in     (IF_allow_in),
      .ID_allow_in     (ID_allow_in),
      .ID_valid        (ID_valid),
      .ID_bus          (ID_bus),
      .flush           (flush),
      .flush_keep_head (flush_keep_head),
      .occupancy       (occupancy),
      .flush_cnt       (flush_cnt),
      .squash_cnt      (squash_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ifo;
      logic [31:0] pc;
      logic        pr;
      logic        ida;
      logic        fl;
      logic        kh;
      logic [1:0]  occ;
      logic [64:0] bus;
      int          fc;
      int          sc;
   } vec_t;

   vec_t tv[$];

   function automatic logic [31:0] ins(input logic [31:0] pc);
      if (pc == 32'h34) return 32'h24010001;
      if (pc == 32'h38) return 32'h24020002;
      return {16'h2400, pc[15:0]};
   endfunction

   function automatic logic [64:0] ent(input logic p,
                                       input logic [31:0] pc);
      return {p, pc, ins(pc)};
   endfunction

   function automatic vec_t mkv(
      input logic ifo, input logic [31:0] pc, input logic pr,
      input logic ida, input logic fl, input logic kh,
      input logic [1:0] occ, input logic [64:0] bus,
      input int fc, input int sc);
      vec_t v;
      v.ifo = ifo; v.pc = pc; v.pr = pr; v.ida = ida;
      v.fl = fl; v.kh = kh; v.occ = occ; v.bus = bus;
      v.fc = fc; v.sc = sc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [64:0] got,
                      input logic [64:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] occ,
                          input logic [64:0] bus, input int fc,
                          input int sc);
      chk({tag, " occupancy"}, 65'(occupancy), 65'(occ));
      chk({tag, " ID_valid"}, 65'(ID_valid), 65'(occ != 2'd0));
      chk({tag, " IF_allow_in"}, 65'(IF_allow_in), 65'(occ != 2'd2));
      chk({tag, " ID_bus"}, ID_bus, bus);
      chk({tag, " flush_cnt"}, 65'(flush_cnt), 65'(fc));
      chk({tag, " squash_cnt"}, 65'(squash_cnt), 65'(sc));
   endtask

   task automatic drive(input logic ifo, input logic [31:0] pc,
                        input logic pr, input logic ida,
                        input logic fl, input logic kh);
      IF_over         = ifo;
      IF_ID_bus       = {pc, ins(pc)};
      IF_pred_taken   = pr;
      ID_allow_in     = ida;
      flush           = fl;
      flush_keep_head = kh;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // cycle: inputs at negedge, sample 1 time unit after posedge
   task automatic cyc(input logic ifo, input logic [31:0] pc,
                      input logic pr, input logic ida,
                      input logic fl, input logic kh);
      @(negedge clk);
      drive(ifo, pc, pr, ida, fl, kh);
      @(posedge clk);
      #1;
   endtask

   // behavioural model state
   logic [64:0] mq[$];
   int          mfc;
   int          msc;

   task automatic model_step(input logic ifo, input logic [64:0] e,
                             input logic ida, input logic fl,
                             input logic kh);
      int          sz;
      bit          off;
      bit          pp;
      logic [64:0] keep;
      sz  = mq.size();
      off = ifo && (sz != 2);
      pp  = (sz != 0) && ida;
      if (fl) begin
         mfc = (mfc + 1 > SAT) ? SAT : mfc + 1;
         if (kh && !pp && sz > 0) begin
            keep = mq[0];
            mq.delete();
            mq.push_back(keep);
            msc += sz - 1 + int'(off);
         end else begin
            mq.delete();
            msc += sz - int'(pp) + int'(off);
         end
         if (msc > SAT) msc = SAT;
      end else begin
         if (pp) void'(mq.pop_front());
         if (off) mq.push_back(e);
      end
   endtask

   initial begin
      logic [31:0] pc;
      logic        ifo, pr, ida, fl, kh;
      logic [64:0] mbus;

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #12;
      reset = 1'b0;
      #1;
      chk_all("reset", 2'd0, 65'h0, 0, 0);

      tv.push_back(mkv(1, 32'h34, 0, 0, 0, 0, 1, ent(0, 32'h34), 0, 0));
      tv.push_back(mkv(1, 32'h38, 0, 0, 0, 0, 2, ent(0, 32'h34), 0, 0));
      tv.push_back(mkv(1, 32'h3C, 0, 0, 0, 0, 2, ent(0, 32'h34), 0, 0));
      tv.push_back(mkv(0, 32'h00, 0, 1, 0, 0, 1, ent(0, 32'h38), 0, 0));
      tv.push_back(mkv(0, 32'h00, 0, 1, 0, 0, 0, 65'h0, 0, 0));
      tv.push_back(mkv(1, 32'h40, 1, 0, 0, 0, 1, ent(1, 32'h40), 0, 0));
      tv.push_back(mkv(1, 32'h44, 0, 0, 0, 0, 2, ent(1, 32'h40), 0, 0));
      tv.push_back(mkv(1, 32'h48, 0, 0, 1, 0, 0, 65'h0, 1, 2));
      tv.push_back(mkv(1, 32'h40, 1, 0, 0, 0, 1, ent(1, 32'h40), 1, 2));
      tv.push_back(mkv(1, 32'h44, 0, 0, 0, 0, 2, ent(1, 32'h40), 1, 2));
      tv.push_back(mkv(0, 32'h00, 0, 0, 1, 1, 1, ent(1, 32'h40), 2, 3));
      tv.push_back(mkv(1, 32'h50, 0, 1, 1, 1, 0, 65'h0, 3, 4));
      tv.push_back(mkv(1, 32'h54, 0, 0, 1, 0, 0, 65'h0, 4, 5));
      tv.push_back(mkv(1, 32'h58, 0, 0, 0, 0, 1, ent(0, 32'h58), 4, 5));
      tv.push_back(mkv(1, 32'h5C, 0, 1, 1, 0, 0, 65'h0, 5, 6));

      foreach (tv[i]) begin
         cyc(tv[i].ifo, tv[i].pc, tv[i].pr, tv[i].ida,
             tv[i].fl, tv[i].kh);
         chk_all($sformatf("vec%0d", i), tv[i].occ, tv[i].bus,
                 tv[i].fc, tv[i].sc);
      end

      // asynchronous reset between edges with two entries held
      do_reset();
      cyc(1, 32'h60, 0, 0, 0, 0);
      cyc(1, 32'h64, 0, 0, 0, 0);
      chk("pre-reset occupancy", 65'(occupancy), 65'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset ID_valid", 65'(ID_valid), 65'd0);
      chk("async reset occupancy", 65'(occupancy), 65'd0);
      chk("async reset ID_bus", ID_bus, 65'h0);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post-reset IF_allow_in", 65'(IF_allow_in), 65'd1);

      // streaming: one entry in flight, no bubbles
      for (int k = 0; k < 8; k++) begin
         pc = 32'h34 + 32'(4 * k);
         cyc(1, pc, 0, 1, 0, 0);
         chk_all($sformatf("stream%0d", k), 2'd1, ent(0, pc), 0, 0);
      end
      cyc(0, 0, 0, 1, 0, 0);
      chk_all("stream drain", 2'd0, 65'h0, 0, 0);

      // saturation of flush_cnt
      do_reset();
      for (int k = 0; k < 20; k++) begin
         cyc(0, 0, 0, 0, 1, 0);
         chk($sformatf("sat flush_cnt %0d", k), 65'(flush_cnt),
             65'((k + 1 > SAT) ? SAT : k + 1));
      end

      // randomized traffic against the queue model
      do_reset();
      mq.delete();
      mfc = 0;
      msc = 0;
      for (int k = 0; k < 600; k++) begin
         ifo = 1'($urandom_range(0, 3) != 0);
         pc  = {$urandom_range(0, 16'hFFFF), 2'b00};
         pr  = 1'($urandom);
         ida = 1'($urandom_range(0, 2) != 0);
         fl  = 1'($urandom_range(0, 9) == 0);
         kh  = 1'($urandom);
         if (k == 300) begin
            do_reset();
            mq.delete();
            mfc = 0;
            msc = 0;
         end
         model_step(ifo, ent(pr, pc), ida, fl, kh);
         cyc(ifo, pc, pr, ida, fl, kh);
         mbus = (mq.size() != 0) ? mq[0] : 65'h0;
         chk_all($sformatf("rand%0d", k), 2'(mq.size()), mbus,
                 mfc, msc);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
